// File: rtl/vend_pkg.sv
// Shared definitions for the vending front end and the change dispenser.
package vend_pkg;

   localparam logic [1:0] R0  = 2'b00;
   localparam logic [1:0] R5  = 2'b01;
   localparam logic [1:0] R10 = 2'b10;
   localparam logic [1:0] R15 = 2'b11;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_10   = 2'b01;
   localparam logic [1:0] COIN_20   = 2'b10;

   localparam int unsigned PRICE = 15;

   typedef enum logic [2:0] {
      StIdle,
      StVend,
      StCoinPulse,
      StCoinWait,
      StFinish,
      StFault
   } disp_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous sensor plus a one-cycle rising-edge pulse.
module sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic rise
);

   logic s1_q, s2_q, s3_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= din;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/change_dispenser.sv
// Releases the product, then pays change one 5 tk coin at a time, each confirmed by the
// hopper exit sensor; a missing confirmation latches a fault until reset.
module change_dispenser #(
   parameter int unsigned PULSE_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req,
   input  logic       buy,
   input  logic [1:0] chg,
   input  logic       coin_sense,
   output logic       vend,
   output logic       coin_out,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [1:0] coins_left
);
   import vend_pkg::*;

   localparam int unsigned CntMax = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES
                                                                      : TIMEOUT_CYCLES;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam logic [CntW-1:0] PulseLast = CntW'(PULSE_CYCLES - 1);
   localparam logic [CntW-1:0] WaitLast  = CntW'(TIMEOUT_CYCLES - 1);

   disp_state_e     state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      coins_q, coins_d;
   logic            vend_q, coin_q, busy_q, done_q, fault_q;
   logic            sense_rise;

   sync_edge u_sense (
      .clock (clock),
      .reset (reset),
      .din   (coin_sense),
      .rise  (sense_rise)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      coins_d = coins_q;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (req) begin
               coins_d = chg;
               if (buy)            state_d = StVend;
               else if (chg != R0) state_d = StCoinPulse;
               else                state_d = StFinish;
            end
         end
         StVend: begin
            if (cnt_q == PulseLast) begin
               cnt_d   = '0;
               state_d = (coins_q != R0) ? StCoinPulse : StFinish;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StCoinPulse: begin
            if (cnt_q == PulseLast) begin
               cnt_d   = '0;
               state_d = StCoinWait;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StCoinWait: begin
            // A confirmation wins over a timeout landing in the same cycle.
            if (sense_rise) begin
               cnt_d = '0;
               if (coins_q != R0) coins_d = coins_q - 2'd1;
               state_d = (coins_q > 2'd1) ? StCoinPulse : StFinish;
            end else if (cnt_q == WaitLast) begin
               cnt_d   = '0;
               state_d = StFault;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StFinish: state_d = StIdle;
         StFault:  state_d = StFault;
         default:  state_d = StIdle;
      endcase
   end

   // Outputs are registered from the next state so they track the state without decode glitches.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         coins_q <= '0;
         vend_q  <= 1'b0;
         coin_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         coins_q <= coins_d;
         vend_q  <= (state_d == StVend);
         coin_q  <= (state_d == StCoinPulse);
         busy_q  <= (state_d != StIdle);
         done_q  <= (state_d == StFinish);
         fault_q <= (state_d == StFault);
      end
   end

   assign vend       = vend_q;
   assign coin_out   = coin_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fault      = fault_q;
   assign coins_left = coins_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: vector table through a scoreboard plus hand-written reset,
// fault and abort sequences, with a behavioural hopper sensor.
module tb_change_dispenser;

   localparam int unsigned P = 4;
   localparam int unsigned T = 100;

   logic       clock = 1'b0;
   logic       reset, req, buy;
   logic [1:0] chg;
   logic       coin_sense = 1'b0;
   logic       vend, coin_out, busy, done, fault;
   logic [1:0] coins_left;

   int  checks = 0;
   int  errors = 0;
   bit  toggle_en = 1'b0;
   bit  respond_en = 1'b0;

   typedef struct {
      string      name;
      logic       buy;
      logic [1:0] chg;
      bit         respond;
      bit         req_again;
      int         exp_vend;
      int         exp_coins;
      int         exp_end_cyc;
      bit         exp_fault;
      logic [1:0] exp_left;
   } vec_t;

   vec_t vecs[7];
   vec_t exp_q[$];

   change_dispenser #(.PULSE_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
      .clock      (clock),
      .reset      (reset),
      .req        (req),
      .buy        (buy),
      .chg        (chg),
      .coin_sense (coin_sense),
      .vend       (vend),
      .coin_out   (coin_out),
      .busy       (busy),
      .done       (done),
      .fault      (fault),
      .coins_left (coins_left)
   );

   always #5 clock = ~clock;

   // Hopper model: 3-cycle sensor pulse starting 5 cycles after each coin pulse ends.
   int   dly = 0;
   int   hi = 0;
   bit   tgl_ph = 1'b0;
   logic prev_coin = 1'b0;
   always @(negedge clock) begin
      if (toggle_en) begin
         tgl_ph = ~tgl_ph;
         if (tgl_ph) coin_sense = ~coin_sense;
         dly = 0;
         hi  = 0;
      end else if (hi > 0) begin
         hi = hi - 1;
         if (hi == 0) coin_sense = 1'b0;
      end else if (dly > 0) begin
         dly = dly - 1;
         if (dly == 0) begin
            coin_sense = 1'b1;
            hi = 3;
         end
      end else begin
         coin_sense = 1'b0;
         if (prev_coin && !coin_out && respond_en) dly = 5;
      end
      prev_coin = coin_out;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic b, input logic [1:0] c,
                               input bit rsp, input bit again, input int ev, input int ec,
                               input int ecyc, input bit ef, input logic [1:0] el);
      vec_t v;
      v.name = name; v.buy = b; v.chg = c; v.respond = rsp; v.req_again = again;
      v.exp_vend = ev; v.exp_coins = ec; v.exp_end_cyc = ecyc; v.exp_fault = ef;
      v.exp_left = el;
      return v;
   endfunction

   task automatic run_txn(input vec_t v);
      int         vend_n = 0, vend_first = -1, coin_n = 0, done_n = 0;
      int         end_cyc = -1, busy_low = -1, overlap = 0, left_bad = 0;
      logic [1:0] left_first = 2'b00, prev_left;
      logic       pc = 1'b0;
      bit         finished = 1'b0;
      vec_t       e;
      respond_en = v.respond;
      @(negedge clock);
      req = 1'b1; buy = v.buy; chg = v.chg;
      exp_q.push_back(v);
      prev_left = v.chg;
      for (int cyc = 1; cyc <= 600 && !finished; cyc++) begin
         @(negedge clock);
         req = v.req_again && (cyc == 3);
         if (req) begin buy = 1'b1; chg = 2'b11; end
         if (vend) begin vend_n++; if (vend_first < 0) vend_first = cyc; end
         if (coin_out && !pc) coin_n++;
         pc = coin_out;
         if (vend && coin_out) overlap++;
         if (cyc == 1) left_first = coins_left;
         else if (coins_left > prev_left || (prev_left - coins_left) > 2'd1) left_bad++;
         prev_left = coins_left;
         if (done) begin done_n++; if (end_cyc < 0) end_cyc = cyc; end
         if (fault) begin end_cyc = cyc; finished = 1'b1; end
         else if (done_n > 0 && !busy) begin busy_low = cyc; finished = 1'b1; end
      end
      req = 1'b0;
      check({v.name, "_completed"}, finished, 1);
      e = exp_q.pop_front();
      check({e.name, "_vend_cycles"}, vend_n, e.exp_vend);
      if (e.exp_vend > 0) check({e.name, "_vend_first"}, vend_first, 1);
      check({e.name, "_coin_pulses"}, coin_n, e.exp_coins);
      check({e.name, "_overlap"}, overlap, 0);
      check({e.name, "_left_latched"}, left_first, e.chg);
      check({e.name, "_left_steps"}, left_bad, 0);
      check({e.name, "_fault"}, fault, e.exp_fault);
      check({e.name, "_coins_left"}, coins_left, e.exp_left);
      if (e.exp_fault) begin
         check({e.name, "_busy_in_fault"}, busy, 1);
         check({e.name, "_no_done"}, done_n, 0);
      end else begin
         check({e.name, "_done_pulses"}, done_n, 1);
         check({e.name, "_busy_low"}, busy_low, end_cyc + 1);
      end
      if (e.exp_end_cyc >= 0) check({e.name, "_end_cycle"}, end_cyc, e.exp_end_cyc);
      repeat (3) @(negedge clock);
   endtask

   initial begin
      int bad;
      vecs[0] = mk("buy_r0",        1'b1, 2'b00, 1'b0, 1'b0, P, 0, P + 1, 1'b0, 2'b00);
      vecs[1] = mk("nobuy_r0",      1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 1,     1'b0, 2'b00);
      vecs[2] = mk("buy_r15",       1'b1, 2'b11, 1'b1, 1'b0, P, 3, -1,    1'b0, 2'b00);
      vecs[3] = mk("nobuy_r5_rereq",1'b0, 2'b01, 1'b1, 1'b1, 0, 1, -1,    1'b0, 2'b00);
      vecs[4] = mk("buy_r10",       1'b1, 2'b10, 1'b1, 1'b0, P, 2, -1,    1'b0, 2'b00);
      vecs[5] = mk("nobuy_r15",     1'b0, 2'b11, 1'b1, 1'b0, 0, 3, -1,    1'b0, 2'b00);
      vecs[6] = mk("fault_r10",     1'b0, 2'b10, 1'b0, 1'b0, 0, 1, 1 + P + T, 1'b1, 2'b10);

      reset = 1'b1; req = 1'b0; buy = 1'b0; chg = 2'b00;
      toggle_en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         check("reset_outputs", {vend, coin_out, busy, done, fault, coins_left}, 0);
      end
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         if (vend || coin_out || busy || done || fault || coins_left != 2'b00) bad++;
      end
      check("idle_sense_ignored", bad, 0);
      toggle_en = 1'b0;
      repeat (4) @(negedge clock);

      for (int i = 0; i < 7; i++) run_txn(vecs[i]);

      // In FAULT a new request is ignored and state holds until reset.
      @(negedge clock);
      req = 1'b1; buy = 1'b1; chg = 2'b01;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         req = 1'b0;
         if (!fault || !busy || vend || coin_out || done || coins_left != 2'b10) bad++;
      end
      check("fault_holds", bad, 0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("fault_cleared", {fault, busy, coins_left}, 0);
      repeat (3) @(negedge clock);

      // Reset in the middle of a coin pulse aborts the transaction.
      respond_en = 1'b0;
      req = 1'b1; buy = 1'b0; chg = 2'b11;
      bad = 1;
      for (int i = 0; i < 20 && bad != 0; i++) begin
         @(negedge clock);
         req = 1'b0;
         if (coin_out) bad = 0;
      end
      check("abort_coin_seen", bad, 0);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("abort_outputs", {vend, coin_out, busy, done, fault, coins_left}, 0);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         if (coin_out || vend || busy) bad++;
      end
      check("abort_quiet", bad, 0);
      run_txn(mk("after_abort", 1'b1, 2'b01, 1'b1, 1'b0, P, 1, -1, 1'b0, 2'b00));

      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
